// File: rtl/hba_pkg.sv
// Shared HBA definitions: arbiter FSM state encodings and sizing helpers.
// Other HBA masters and benches import this package.
package hba_pkg;

  localparam logic [1:0] HBA_ST_IDLE     = 2'd0;
  localparam logic [1:0] HBA_ST_GRANT    = 2'd1;
  localparam logic [1:0] HBA_ST_WAIT_SEL = 2'd2;
  localparam logic [1:0] HBA_ST_OWNED    = 2'd3;

  // Width of the select-timeout counter. A timeout of 0 still needs one bit.
  function automatic int hba_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/hba_arbiter_rr_if.sv
// Request/grant bus between HBA masters and the arbiter.
// master: requesters and bus-select driver; slave: the arbiter.
interface hba_arbiter_rr_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int OWNER_W = $clog2(NUM_MASTERS);

  logic                   hba_select;
  logic [NUM_MASTERS-1:0] hba_mrequest;
  logic [NUM_MASTERS-1:0] hba_mgrant;
  logic [OWNER_W-1:0]     hba_mowner;
  logic                   hba_arb_busy;
  logic                   hba_arb_timeout;

  modport master (
    output hba_select,
    output hba_mrequest,
    input  hba_mgrant,
    input  hba_mowner,
    input  hba_arb_busy,
    input  hba_arb_timeout
  );

  modport slave (
    input  hba_select,
    input  hba_mrequest,
    output hba_mgrant,
    output hba_mowner,
    output hba_arb_busy,
    output hba_arb_timeout
  );

endinterface

// File: rtl/hba_rr_pick.sv
// Combinational winner search: rotating priority starting after ptr,
// or fixed priority (lowest index wins) when rr_mode is low.
module hba_rr_pick #(
  parameter  int NUM_MASTERS = 4,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  input  logic                   rr_mode,
  output logic [IDX_W-1:0]       winner,
  output logic                   any_valid
);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    // Candidates are visited in priority order; the first hit wins. In
    // rotating mode the pointer itself is visited last.
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (rr_mode) begin
        idx = (int'(ptr) + 1 + i) % NUM_MASTERS;
      end else begin
        idx = i;
      end
      if (!any_valid && req[IDX_W'(idx)]) begin
        any_valid = 1'b1;
        winner    = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/hba_arbiter_rr.sv
// HBA bus arbiter: grants one master per arbitration round with a one-cycle
// registered pulse, then tracks bus ownership via hba_select.
module hba_arbiter_rr
  import hba_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ROUND_ROBIN    = 1,
  parameter int SELECT_TIMEOUT = 15
) (
  input logic             hba_clk,
  input logic             hba_reset_n,
  hba_arbiter_rr_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = hba_cnt_width(SELECT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((SELECT_TIMEOUT > 0) ? SELECT_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]             state_q,   state_d;
  logic [NUM_MASTERS-1:0] grant_q,   grant_d;
  logic [IDX_W-1:0]       owner_q,   owner_d;
  logic [IDX_W-1:0]       ptr_q,     ptr_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic                   timeout_q, timeout_d;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  hba_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .req       (bus.hba_mrequest),
    .ptr       (ptr_q),
    .rr_mode   (ROUND_ROBIN != 0),
    .winner    (pick_idx),
    .any_valid (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = '0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      HBA_ST_IDLE: begin
        // An externally owned bus (select high) is never granted over.
        if (!bus.hba_select && pick_valid) begin
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          ptr_d             = pick_idx;
          cnt_d             = '0;
          state_d           = HBA_ST_GRANT;
        end
      end

      HBA_ST_GRANT: begin
        state_d = bus.hba_select ? HBA_ST_OWNED : HBA_ST_WAIT_SEL;
      end

      HBA_ST_WAIT_SEL: begin
        if (bus.hba_select) begin
          state_d = HBA_ST_OWNED;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // The pointer already moved on grant, so a dead master loses its turn.
          if (SELECT_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
            state_d   = HBA_ST_IDLE;
            timeout_d = 1'b1;
          end
        end
      end

      HBA_ST_OWNED: begin
        if (!bus.hba_select) begin
          state_d = HBA_ST_IDLE;
        end
      end

      default: state_d = HBA_ST_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the same pre-edge values.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      state_q   <= HBA_ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= IDX_W'(NUM_MASTERS - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.hba_mgrant      = grant_q;
  assign bus.hba_mowner      = owner_q;
  assign bus.hba_arb_busy    = (state_q != HBA_ST_IDLE);
  assign bus.hba_arb_timeout = timeout_q;

endmodule

// File: tb/tb_hba_arbiter_rr.sv
// Scoreboard bench for hba_arbiter_rr: three instances (rotating, fixed
// priority, 16-master without timeout) sharing one clock and reset.
module tb_hba_arbiter_rr;

  logic hba_clk = 1'b0;
  logic hba_reset_n = 1'b1;
  always #5 hba_clk = ~hba_clk;

  hba_arbiter_rr_if #(.NUM_MASTERS(4))  bus_a ();
  hba_arbiter_rr_if #(.NUM_MASTERS(4))  bus_b ();
  hba_arbiter_rr_if #(.NUM_MASTERS(16)) bus_c ();

  hba_arbiter_rr #(.NUM_MASTERS(4), .ROUND_ROBIN(1), .SELECT_TIMEOUT(15)) u_a (
    .hba_clk (hba_clk), .hba_reset_n (hba_reset_n), .bus (bus_a));
  hba_arbiter_rr #(.NUM_MASTERS(4), .ROUND_ROBIN(0), .SELECT_TIMEOUT(15)) u_b (
    .hba_clk (hba_clk), .hba_reset_n (hba_reset_n), .bus (bus_b));
  hba_arbiter_rr #(.NUM_MASTERS(16), .ROUND_ROBIN(1), .SELECT_TIMEOUT(0)) u_c (
    .hba_clk (hba_clk), .hba_reset_n (hba_reset_n), .bus (bus_c));

  // Index 0/1/2 selects bus_a/bus_b/bus_c.
  logic        sel  [3];
  logic [15:0] req  [3];
  logic [15:0] gnt  [3];
  logic [3:0]  own  [3];
  logic        busy [3];
  logic        tmo  [3];

  assign bus_a.hba_select   = sel[0];
  assign bus_b.hba_select   = sel[1];
  assign bus_c.hba_select   = sel[2];
  assign bus_a.hba_mrequest = req[0][3:0];
  assign bus_b.hba_mrequest = req[1][3:0];
  assign bus_c.hba_mrequest = req[2];

  assign gnt[0]  = {12'd0, bus_a.hba_mgrant};
  assign gnt[1]  = {12'd0, bus_b.hba_mgrant};
  assign gnt[2]  = bus_c.hba_mgrant;
  assign own[0]  = {2'd0, bus_a.hba_mowner};
  assign own[1]  = {2'd0, bus_b.hba_mowner};
  assign own[2]  = bus_c.hba_mowner;
  assign busy[0] = bus_a.hba_arb_busy;
  assign busy[1] = bus_b.hba_arb_busy;
  assign busy[2] = bus_c.hba_arb_busy;
  assign tmo[0]  = bus_a.hba_arb_timeout;
  assign tmo[1]  = bus_b.hba_arb_timeout;
  assign tmo[2]  = bus_c.hba_arb_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  // Waits up to budget falling edges for a grant on bus w; g stays 0 if none.
  task automatic wait_grant(input int w, input int budget,
                            output logic [15:0] g, output int waited);
    g = '0;
    waited = 0;
    while (waited < budget) begin
      @(negedge hba_clk);
      waited++;
      if (gnt[w] != '0) begin
        g = gnt[w];
        break;
      end
    end
  endtask

  // Answers a grant with hba_select for hold cycles; called on the grant edge.
  task automatic serve(input int w, input int hold);
    sel[w] = 1'b1;
    repeat (hold) @(negedge hba_clk);
    sel[w] = 1'b0;
  endtask

  task automatic test_reset();
    for (int w = 0; w < 3; w++) begin
      sel[w] = 1'b0;
      req[w] = '0;
    end
    #2 hba_reset_n = 1'b0;
    @(negedge hba_clk);
    for (int w = 0; w < 3; w++) begin
      n_cmp++;
      if ({gnt[w], own[w], busy[w], tmo[w]} !== 22'd0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: gnt=%h own=%0d busy=%b tmo=%b want all 0",
                 w, gnt[w], own[w], busy[w], tmo[w]);
      end
    end
    req[0] = 16'h000F;
    repeat (3) begin
      @(negedge hba_clk);
      n_cmp++;
      if (gnt[0] !== 16'd0 || busy[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL grant_in_reset: gnt=%h busy=%b want 0000/0", gnt[0], busy[0]);
      end
    end
    hba_reset_n = 1'b1;
  endtask

  task automatic test_rr_rotation();
    logic [15:0] g;
    int waited, e;
    for (int i = 0; i < 5; i++) exp_q.push_back(i % 4);
    for (int i = 0; i < 5; i++) begin
      wait_grant(0, 8, g, waited);
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== (16'd1 << e)) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: got %h want %h", i, g, 16'd1 << e);
      end
      n_cmp++;
      if (own[0] !== 4'(e)) begin
        n_bad++;
        $display("FAIL rr_owner[%0d]: got %0d want %0d", i, own[0], e);
      end
      if (i == 4) req[0] = '0;
      sel[0] = 1'b1;
      @(negedge hba_clk);
      n_cmp++;
      if (gnt[0] !== 16'd0 || busy[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL rr_pulse[%0d]: gnt=%h busy=%b want 0000/1", i, gnt[0], busy[0]);
      end
      @(negedge hba_clk);
      sel[0] = 1'b0;
      @(negedge hba_clk);
      n_cmp++;
      if (busy[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_idle[%0d]: busy=%b want 0", i, busy[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] g;
    int waited, e;
    req[0] = 16'h0002;
    repeat (3) exp_q.push_back(1);
    wait_grant(0, 8, g, waited);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== (16'd1 << e)) begin
        n_bad++;
        $display("FAIL b2b_grant[%0d]: got %h want %h", i, g, 16'd1 << e);
      end
      if (i == 2) req[0] = '0;
      serve(0, 1);
      if (i < 2) begin
        wait_grant(0, 8, g, waited);
        n_cmp++;
        if (waited !== 2) begin
          n_bad++;
          $display("FAIL b2b_spacing[%0d]: next grant %0d cycles after select drop, want 2",
                   i, waited);
        end
      end
    end
    repeat (2) @(negedge hba_clk);
  endtask

  task automatic test_timeout();
    logic [15:0] g;
    int waited, e;
    req[0] = 16'h0004;
    exp_q.push_back(2);
    exp_q.push_back(2);
    wait_grant(0, 8, g, waited);
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== (16'd1 << e)) begin
      n_bad++;
      $display("FAIL to_grant: got %h want %h", g, 16'd1 << e);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge hba_clk);
      n_cmp++;
      if (k < 16) begin
        if ({gnt[0] != 16'd0, busy[0], tmo[0]} !== 3'b010) begin
          n_bad++;
          $display("FAIL to_wait[%0d]: gnt=%h busy=%b tmo=%b want 0000/1/0",
                   k, gnt[0], busy[0], tmo[0]);
        end
      end else if ({gnt[0] != 16'd0, busy[0], tmo[0]} !== 3'b001) begin
        n_bad++;
        $display("FAIL to_pulse: gnt=%h busy=%b tmo=%b want 0000/0/1",
                 gnt[0], busy[0], tmo[0]);
      end
    end
    wait_grant(0, 2, g, waited);
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== (16'd1 << e) || waited !== 1 || tmo[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL to_regrant: got %h after %0d tmo=%b want %h after 1 tmo=0",
               g, waited, tmo[0], 16'd1 << e);
    end
    req[0] = '0;
    serve(0, 1);
    @(negedge hba_clk);
  endtask

  task automatic test_external_select();
    logic [15:0] g;
    int waited, e;
    sel[0] = 1'b1;
    req[0] = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge hba_clk);
      n_cmp++;
      if (gnt[0] !== 16'd0 || busy[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL ext_hold[%0d]: gnt=%h busy=%b want 0000/0", k, gnt[0], busy[0]);
      end
    end
    sel[0] = 1'b0;
    exp_q.push_back(0);
    wait_grant(0, 1, g, waited);
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== (16'd1 << e)) begin
      n_bad++;
      $display("FAIL ext_release: got %h want %h", g, 16'd1 << e);
    end
    req[0] = '0;
    serve(0, 1);
    @(negedge hba_clk);
  endtask

  task automatic test_fixed();
    logic [15:0] g;
    int waited, e;
    req[1] = 16'h000A;
    repeat (4) exp_q.push_back(1);
    for (int i = 0; i < 4; i++) begin
      wait_grant(1, 8, g, waited);
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== (16'd1 << e) || own[1] !== 4'(e)) begin
        n_bad++;
        $display("FAIL fixed_grant[%0d]: got %h owner %0d want %h owner %0d",
                 i, g, own[1], 16'd1 << e, e);
      end
      if (i == 3) req[1] = '0;
      serve(1, 1);
    end
    @(negedge hba_clk);
  endtask

  task automatic test_wide();
    logic [15:0] g;
    int waited, e, bad_cycles;
    req[2] = 16'h8000;
    exp_q.push_back(15);
    exp_q.push_back(0);
    exp_q.push_back(15);
    exp_q.push_back(0);
    for (int i = 0; i < 4; i++) begin
      wait_grant(2, 8, g, waited);
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== (16'd1 << e) || own[2] !== 4'(e)) begin
        n_bad++;
        $display("FAIL wide_grant[%0d]: got %h owner %0d want %h owner %0d",
                 i, g, own[2], 16'd1 << e, e);
      end
      req[2] = (i == 3) ? 16'h0000 : 16'h8001;
      serve(2, 1);
    end
    @(negedge hba_clk);
    // No timeout configured: an unanswered grant waits indefinitely.
    req[2] = 16'h0004;
    exp_q.push_back(2);
    wait_grant(2, 8, g, waited);
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== (16'd1 << e)) begin
      n_bad++;
      $display("FAIL wide_nto_grant: got %h want %h", g, 16'd1 << e);
    end
    req[2] = '0;
    bad_cycles = 0;
    repeat (40) begin
      @(negedge hba_clk);
      if (busy[2] !== 1'b1 || tmo[2] !== 1'b0 || gnt[2] !== 16'd0) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL wide_no_timeout: %0d of 40 cycles left WAIT_SEL or pulsed, want 0",
               bad_cycles);
    end
    serve(2, 1);
    @(negedge hba_clk);
    n_cmp++;
    if (busy[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL wide_release: busy=%b want 0", busy[2]);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] g;
    int waited, e;
    req[0] = 16'h0004;
    exp_q.push_back(2);
    wait_grant(0, 8, g, waited);
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== (16'd1 << e)) begin
      n_bad++;
      $display("FAIL mid_grant: got %h want %h", g, 16'd1 << e);
    end
    sel[0] = 1'b1;
    @(negedge hba_clk);
    n_cmp++;
    if (busy[0] !== 1'b1 || own[0] !== 4'd2) begin
      n_bad++;
      $display("FAIL mid_owned: busy=%b owner=%0d want 1/2", busy[0], own[0]);
    end
    #2 hba_reset_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt[0] !== 16'd0 || busy[0] !== 1'b0 || own[0] !== 4'd0) begin
      n_bad++;
      $display("FAIL mid_async_reset: gnt=%h busy=%b owner=%0d want 0000/0/0",
               gnt[0], busy[0], own[0]);
    end
    sel[0] = 1'b0;
    req[0] = 16'h000F;
    @(negedge hba_clk);
    hba_reset_n = 1'b1;
    exp_q.push_back(0);
    wait_grant(0, 4, g, waited);
    e = exp_q.pop_front();
    n_cmp++;
    if (g !== (16'd1 << e)) begin
      n_bad++;
      $display("FAIL mid_first_grant: got %h want %h", g, 16'd1 << e);
    end
    // Reset during the grant pulse itself must kill it without a clock edge.
    #1 hba_reset_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt[0] !== 16'd0 || busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL grant_async_drop: gnt=%h busy=%b want 0000/0", gnt[0], busy[0]);
    end
    req[0] = '0;
    @(negedge hba_clk);
    hba_reset_n = 1'b1;
    @(negedge hba_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_rotation();
    test_back_to_back();
    test_timeout();
    test_external_select();
    test_fixed();
    test_wide();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
